// File: rtl/var_delay_line_pkg.sv
// Shared audio-path definitions: sample width, delay-line FSM states and the delay clamp.
package var_delay_line_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Map a requested delay onto the usable range 1..max_len.
  function automatic int unsigned clamp_delay(input int unsigned d, input int unsigned max_len);
    if (d == 0) return 1;
    if (d > max_len) return max_len;
    return d;
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port read-first RAM with a registered read port, shaped for block RAM inference.
module delay_ram #(
  parameter int  WIDTH   = 16,
  parameter int  MAX_LEN = 1024,
  localparam int AW      = $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [MAX_LEN];
  logic [WIDTH-1:0] rdata_q;

  // Nonblocking write and read on the same edge give old data when raddr == waddr.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/var_delay_line.sv
// Runtime-adjustable circular-buffer sample delay with zero-clearing sweep after reset or clear.
module var_delay_line
  import var_delay_line_pkg::*;
#(
  parameter int  WIDTH   = SAMPLE_W,
  parameter int  MAX_LEN = 1024,
  localparam int AW      = $clog2(MAX_LEN),
  localparam int DW      = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic [DW-1:0]    delay,
  input  logic             clear,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   wp_q, wp_d;
  logic            busy_q, busy_d;
  logic            zero_q, zero_d;

  logic             we, re;
  logic [AW-1:0]    waddr, raddr;
  logic [WIDTH-1:0] wdata, rdata;
  int unsigned      dly_eff, rd_int;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wp_d    = wp_q;
    busy_d  = busy_q;
    zero_d  = zero_q;
    we      = 1'b0;
    re      = 1'b0;
    waddr   = wp_q;
    wdata   = in;

    dly_eff = clamp_delay(32'(delay), MAX_LEN);
    rd_int  = (32'(wp_q) < dly_eff) ? 32'(wp_q) + 32'(MAX_LEN) - dly_eff
                                    : 32'(wp_q) - dly_eff;
    raddr   = AW'(rd_int);

    unique case (state_q)
      ST_CLEAR: begin
        we    = 1'b1;
        waddr = addr_q;
        wdata = '0;
        if (clear) begin
          addr_d = '0;
        end else if (addr_q == AW'(MAX_LEN - 1)) begin
          state_d = ST_RUN;
          addr_d  = '0;
          wp_d    = '0;
          busy_d  = 1'b0;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      ST_RUN: begin
        if (clear) begin
          state_d = ST_CLEAR;
          addr_d  = '0;
          wp_d    = '0;
          busy_d  = 1'b1;
          zero_d  = 1'b1;
        end else if (enable) begin
          we     = 1'b1;
          re     = 1'b1;
          zero_d = 1'b0;
          wp_d   = (wp_q == AW'(MAX_LEN - 1)) ? '0 : wp_q + AW'(1);
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_CLEAR;
      addr_q  <= '0;
      wp_q    <= '0;
      busy_q  <= 1'b1;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wp_q    <= wp_d;
      busy_q  <= busy_d;
      zero_q  <= zero_d;
    end
  end

  delay_ram #(
    .WIDTH  (WIDTH),
    .MAX_LEN(MAX_LEN)
  ) u_ram (
    .clk  (clk),
    .we   (we & resetn),
    .waddr(waddr),
    .wdata(wdata),
    .re   (re & resetn),
    .raddr(raddr),
    .rdata(rdata)
  );

  // The RAM read register is not reset; zero_q masks it from reset/clear until the first read.
  assign out  = zero_q ? '0 : rdata;
  assign busy = busy_q;

endmodule

// File: tb/tb_var_delay_line.sv
// Randomized and directed bench for var_delay_line against a history-queue reference model.
module tb_var_delay_line;

  localparam int W = 12;
  localparam int L = 10;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         enable = 1'b0;
  logic [3:0]   delay = '0;
  logic         clear = 1'b0;
  logic [W-1:0] in_s = '0;
  logic [W-1:0] out;
  logic         busy;

  int checks = 0;
  int failures = 0;

  var_delay_line #(.WIDTH(W), .MAX_LEN(L)) dut (
    .clk   (clk),
    .resetn(resetn),
    .enable(enable),
    .delay (delay),
    .clear (clear),
    .in    (in_s),
    .out   (out),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Reference model: out is the sample D enables back since the last clear, else 0.
  logic [W-1:0] m_hist[$];
  int           m_tot = 0;
  int           m_left = 0;
  bit           m_clear = 1'b0;
  bit           m_valid = 1'b0;
  logic [W-1:0] m_out = '0;

  always @(posedge clk) begin
    int d;
    if (!resetn || (m_valid && clear)) begin
      m_clear = 1'b1;
      m_left  = L;
      m_out   = '0;
      m_tot   = 0;
      m_hist.delete();
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_clear) begin
        m_left--;
        if (m_left == 0) m_clear = 1'b0;
      end else if (enable) begin
        d = (delay == 0) ? 1 : ((int'(delay) > L) ? L : int'(delay));
        m_out = (m_tot >= d) ? m_hist[m_hist.size() - d] : '0;
        m_hist.push_back(in_s);
        if (m_hist.size() > L) void'(m_hist.pop_front());
        m_tot++;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_out", int'(out), int'(m_out));
      check("model_busy", int'(busy), int'(m_clear));
    end
  end

  task automatic step(input logic en, input int dly, input int x, input logic clr);
    enable = en;
    delay  = 4'(dly);
    in_s   = W'(x);
    clear  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input string name, input int dly, input int x, input int exp);
    step(1'b1, dly, x, 1'b0);
    check(name, int'(out), exp);
  endtask

  // Count cycles busy stays high, with random sweep-time enables that must be dropped.
  task automatic count_busy(input string name);
    int n = 0;
    while (busy && n < 3 * L) begin
      n++;
      step(1'(($urandom % 2)), int'($urandom % 16), int'($urandom), 1'b0);
    end
    check(name, n, L);
  endtask

  task automatic do_clear();
    step(1'b0, 0, 0, 1'b1);
    count_busy("clear_busy_len");
  endtask

  initial begin
    int prev;
    int x;
    // 1: reset and sweep
    step(1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    resetn = 1'b1;
    check("reset_out", int'(out), 0);
    count_busy("reset_busy_len");

    // 2: delay 3
    begin
      int ins[8]  = '{1, 2, 3, 4, 5, 0, 0, 0};
      int exps[8] = '{0, 0, 0, 1, 2, 3, 4, 5};
      for (int i = 0; i < 8; i++) pulse("d3_seq", 3, ins[i], exps[i]);
    end
    step(1'b0, 0, 0, 1'b0);

    // 3: maximum delay, over-range delay, zero delay
    do_clear();
    for (int i = 1; i <= 11; i++) pulse("d10", 10, (i == 1) ? 1 : 0, (i == 11) ? 1 : 0);
    do_clear();
    for (int i = 1; i <= 11; i++) pulse("d15", 15, (i == 1) ? 1 : 0, (i == 11) ? 1 : 0);
    do_clear();
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      x = int'($urandom % 4096);
      pulse("d0", 0, x, prev);
      prev = x;
    end
    step(1'b0, 0, 0, 1'b0);

    // 4: ramp across pointer wraps
    do_clear();
    for (int n = 1; n <= 25; n++) pulse("ramp_d4", 4, n, (n > 4) ? n - 4 : 0);
    step(1'b0, 0, 0, 1'b0);

    // 5: hold on enable=0
    do_clear();
    for (int i = 1; i <= 6; i++) pulse("d2_stream", 2, 100 + i, (i > 2) ? 98 + i : 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2, 999, 1'b0);
      check("hold", int'(out), 104);
    end
    pulse("resume", 2, 107, 105);
    pulse("resume", 2, 108, 106);
    step(1'b0, 0, 0, 1'b0);

    // 6: mid-stream clear with buffer full of 7s
    do_clear();
    for (int i = 1; i <= 12; i++) pulse("fill7", 5, 7, (i > 5) ? 7 : 0);
    step(1'b1, 5, 9, 1'b1);
    check("clear_out", int'(out), 0);
    count_busy("clear7_busy_len");
    for (int i = 1; i <= 6; i++) pulse("post_clear", 5, 10 + i, (i == 6) ? 11 : 0);
    step(1'b0, 0, 0, 1'b0);

    // Random phase including clears and resets at any time
    for (int i = 0; i < 600; i++) begin
      resetn = ($urandom % 150) != 0;
      step(1'(($urandom % 4) != 0), int'($urandom % 16), int'($urandom), 1'(($urandom % 70) == 0));
    end
    resetn = 1'b1;
    step(1'b0, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
